// File: rtl/arb_pkg.sv
// Shared types and helpers for the four-requester round-robin arbiter.
package arb_pkg;

    localparam int unsigned NREQ = 4;

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } arb_state_t;

    typedef logic [1:0] idx_t;

    // One-hot encode a requester index.
    function automatic logic [NREQ-1:0] idx2oh(input idx_t i);
        logic [NREQ-1:0] oh;
        oh    = '0;
        oh[i] = 1'b1;
        return oh;
    endfunction

endpackage

// File: rtl/mux4_1.sv
// One-bit 4:1 multiplexer; the datapath is built from WIDTH of these.
module mux4_1 (
    input  logic [3:0] d,
    input  logic [1:0] s,
    output logic       y
);

    assign y = d[s];

endmodule

// File: rtl/rr_pick4.sv
// Combinational circular first-set search over four requests starting at a given index.
module rr_pick4
    import arb_pkg::*;
(
    input  logic [NREQ-1:0] req,
    input  idx_t            start,
    input  logic [NREQ-1:0] excl,
    output logic            found,
    output idx_t            idx
);

    logic [NREQ-1:0] masked;
    idx_t            cand;

    assign masked = req & ~excl;

    always_comb begin
        found = 1'b0;
        idx   = start;
        cand  = start;
        for (int unsigned off = 0; off < NREQ; off++) begin
            cand = start + 2'(off);
            if (!found && masked[cand]) begin
                found = 1'b1;
                idx   = cand;
            end
        end
    end

endmodule

// File: rtl/arb4_rr.sv
// Round-robin arbiter with bounded hold time that steers the granted requester's word to data_out.
module arb4_rr
    import arb_pkg::*;
#(
    parameter int unsigned WIDTH    = 64,
    parameter int unsigned MAX_HOLD = 4
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [NREQ-1:0]       req,
    input  logic [NREQ*WIDTH-1:0] data_in,
    output logic [NREQ-1:0]       gnt,
    output logic [1:0]            sel,
    output logic                  valid,
    output logic [WIDTH-1:0]      data_out
);

    localparam int unsigned HW = $clog2(MAX_HOLD + 1);

    arb_state_t      state_q, state_d;
    idx_t            ptr_q, ptr_d;
    idx_t            sel_q, sel_d;
    logic [HW-1:0]   hold_q, hold_d;
    logic [NREQ-1:0] gnt_q, gnt_d;
    logic            valid_q;

    logic            pick_found;
    idx_t            pick_idx;
    idx_t            pick_start;
    logic [NREQ-1:0] pick_excl;

    // Idle searches from ptr; busy searches past the owner and never re-picks it.
    always_comb begin
        pick_start = ptr_q;
        pick_excl  = '0;
        if (state_q == BUSY) begin
            pick_start = sel_q + 2'(1);
            pick_excl  = idx2oh(sel_q);
        end
    end

    rr_pick4 u_pick (
        .req   (req),
        .start (pick_start),
        .excl  (pick_excl),
        .found (pick_found),
        .idx   (pick_idx)
    );

    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        sel_d   = sel_q;
        hold_d  = hold_q;
        gnt_d   = gnt_q;
        unique case (state_q)
            IDLE: begin
                gnt_d = '0;
                if (pick_found) begin
                    state_d = BUSY;
                    gnt_d   = idx2oh(pick_idx);
                    sel_d   = pick_idx;
                    ptr_d   = pick_idx + 2'(1);
                    hold_d  = HW'(1);
                end
            end
            BUSY: begin
                if (!req[sel_q] || (hold_q >= HW'(MAX_HOLD) && pick_found)) begin
                    // Release or preemption: hand off on this edge when someone waits.
                    if (pick_found) begin
                        gnt_d  = idx2oh(pick_idx);
                        sel_d  = pick_idx;
                        ptr_d  = pick_idx + 2'(1);
                        hold_d = HW'(1);
                    end else begin
                        state_d = IDLE;
                        gnt_d   = '0;
                    end
                end else if (hold_q < HW'(MAX_HOLD)) begin
                    hold_d = hold_q + HW'(1);
                end
            end
            default: begin
                state_d = IDLE;
                gnt_d   = '0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            ptr_q   <= '0;
            sel_q   <= '0;
            hold_q  <= '0;
            gnt_q   <= '0;
            valid_q <= 1'b0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            sel_q   <= sel_d;
            hold_q  <= hold_d;
            gnt_q   <= gnt_d;
            valid_q <= |gnt_d;
        end
    end

    assign gnt   = gnt_q;
    assign sel   = sel_q;
    assign valid = valid_q;

    // Bit-sliced data steering: bit b of every requester word feeds one mux.
    for (genvar b = 0; b < WIDTH; b++) begin : g_mux
        mux4_1 u_mux (
            .d ({data_in[3*WIDTH+b], data_in[2*WIDTH+b], data_in[WIDTH+b], data_in[b]}),
            .s (sel_q),
            .y (data_out[b])
        );
    end

endmodule

// File: tb/tb_arb4_rr.sv
// Directed bench for arb4_rr with hand-computed expected grants and data words.
module tb_arb4_rr;

    localparam int unsigned W = 64;

    logic          clk;
    logic          reset;
    logic [3:0]    req;
    logic [4*W-1:0] data_in;
    logic [3:0]    gnt;
    logic [1:0]    sel;
    logic          valid;
    logic [W-1:0]  data_out;
    logic [W-1:0]  w [4];

    int errors;
    int checks;

    assign data_in = {w[3], w[2], w[1], w[0]};

    arb4_rr #(.WIDTH(W), .MAX_HOLD(4)) dut (
        .clk      (clk),
        .reset    (reset),
        .req      (req),
        .data_in  (data_in),
        .gnt      (gnt),
        .sel      (sel),
        .valid    (valid),
        .data_out (data_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    initial begin
        logic [3:0] exp_g;
        int         own;
        errors = 0;
        checks = 0;
        w[0]   = 64'hAAAA_AAAA_AAAA_AAAA;
        w[1]   = 64'h5555_5555_5555_5555;
        w[2]   = 64'h0123_4567_89AB_CDEF;
        w[3]   = 64'hFFFF_FFFF_FFFF_FFFF;
        reset  = 1'b1;
        req    = 4'b0000;

        // Reset state
        step();
        step();
        chk("rst_gnt", 64'(gnt), 64'h0);
        chk("rst_valid", 64'(valid), 64'h0);
        chk("rst_sel", 64'(sel), 64'h0);

        // Single request from idle
        reset = 1'b0;
        req   = 4'b0100;
        step();
        chk("single_gnt", 64'(gnt), 64'h4);
        chk("single_sel", 64'(sel), 64'h2);
        chk("single_valid", 64'(valid), 64'h1);
        chk("single_data", data_out, 64'h0123_4567_89AB_CDEF);
        req = 4'b0000;
        step();
        chk("drop_gnt", 64'(gnt), 64'h0);
        chk("drop_sel", 64'(sel), 64'h2);
        chk("drop_valid", 64'(valid), 64'h0);

        // All four request after reset: 0,1,2,3,0 with four cycles each
        reset = 1'b1;
        step();
        reset = 1'b0;
        req   = 4'b1111;
        for (int n = 0; n < 20; n++) begin
            step();
            own   = (n / 4) % 4;
            exp_g = 4'b0001 << own;
            chk($sformatf("rr_gnt_%0d", n), 64'(gnt), 64'(exp_g));
            chk($sformatf("rr_data_%0d", n), data_out, w[own]);
        end

        // Lone requester holds, then a late arrival preempts immediately
        reset = 1'b1;
        req   = 4'b0000;
        step();
        reset = 1'b0;
        req   = 4'b0001;
        for (int n = 0; n < 10; n++) begin
            step();
            chk($sformatf("lone_gnt_%0d", n), 64'(gnt), 64'h1);
        end
        req = 4'b1001;
        step();
        chk("preempt_gnt", 64'(gnt), 64'h8);
        chk("preempt_sel", 64'(sel), 64'h3);

        // Release handoff from owner 1 searches from 2
        reset = 1'b1;
        req   = 4'b0000;
        step();
        reset = 1'b0;
        req   = 4'b0010;
        step();
        chk("ho_own1", 64'(gnt), 64'h2);
        req = 4'b0111;
        step();
        chk("ho_hold1", 64'(gnt), 64'h2);
        req = 4'b0101;
        step();
        chk("ho_gnt", 64'(gnt), 64'h4);
        chk("ho_valid", 64'(valid), 64'h1);

        // Reset while owner 1 holds with hold count 2
        reset = 1'b1;
        req   = 4'b0000;
        step();
        reset = 1'b0;
        req   = 4'b0010;
        step();
        step();
        chk("mid_pre_gnt", 64'(gnt), 64'h2);
        reset = 1'b1;
        step();
        chk("mid_rst_gnt", 64'(gnt), 64'h0);
        chk("mid_rst_sel", 64'(sel), 64'h0);
        chk("mid_rst_valid", 64'(valid), 64'h0);
        reset = 1'b0;
        req   = 4'b1010;
        step();
        chk("post_rst_gnt", 64'(gnt), 64'h2);
        chk("post_rst_sel", 64'(sel), 64'h1);

        // Granted word changes mid-grant: data_out follows without a clock edge
        chk("steer_before", data_out, 64'h5555_5555_5555_5555);
        w[1] = 64'hDEAD_BEEF_0BAD_F00D;
        #1;
        chk("steer_after", data_out, 64'hDEAD_BEEF_0BAD_F00D);
        w[0] = 64'h1111_2222_3333_4444;
        #1;
        chk("steer_other", data_out, 64'hDEAD_BEEF_0BAD_F00D);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
